// File: rtl/key_event_ctrl.sv
// Multi-key event controller: classifies debounced key activity as short, long or
// auto-repeat events and queues them round-robin into a valid/ready event FIFO.
module key_event_ctrl #(
  parameter int NUM_KEYS   = 4,
  parameter int FREQ       = 50,
  parameter int LONG_MS    = 1000,
  parameter int REPEAT_MS  = 200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_KEYS-1:0]         key_level,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [$clog2(NUM_KEYS)-1:0] evt_key,
  output logic [1:0]                  evt_type,
  output logic                        overflow,
  input  logic                        clr_overflow
);

  localparam int KW       = $clog2(NUM_KEYS);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int TICK_DIV = FREQ * 1000;
  localparam int TW       = $clog2(TICK_DIV);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [15:0]   LONG_C    = 16'(LONG_MS);
  localparam logic [15:0]   REP_C     = 16'(REPEAT_MS);
  localparam logic [KW:0]   NK_C      = (KW+1)'(NUM_KEYS);
  localparam logic [KW-1:0] LAST_KEY  = KW'(NUM_KEYS - 1);
  localparam logic [AW:0]   FULL_C    = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] EVT_SHORT  = 2'b00;
  localparam logic [1:0] EVT_LONG   = 2'b01;
  localparam logic [1:0] EVT_REPEAT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } key_state_e;

  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic                tick_s;
  logic [NUM_KEYS-1:0] key_q;
  logic [NUM_KEYS-1:0] pend_valid_s, drop_s;
  logic [1:0]          pend_type_s [NUM_KEYS];
  logic [KW-1:0]       rr_ptr_q, rr_ptr_d, grant_idx_s;
  logic                grant_valid_s;
  logic [1:0]          grant_type_s;
  logic [KW+1:0]       fifo_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q, count_d;
  logic                fifo_full_s, push_s, pop_s;
  logic                overflow_q, overflow_d;

  // Millisecond prescaler
  always_comb begin
    tick_s = (tick_cnt_q == TICK_LAST);
    if (tick_s) tick_cnt_d = '0;
    else        tick_cnt_d = tick_cnt_q + TW'(1);
  end

  // Prescaler and key level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      key_q      <= '1;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      key_q      <= key_level;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_state_e  state_q, state_d;
    logic [15:0] ms_q, ms_d, ms_inc_s;
    logic        post_s, grant_s, busy_s, slot_valid_q;
    logic [1:0]  post_type_s, slot_type_q;

    // Press classifier; ms counter saturates so a stuck key cannot wrap
    always_comb begin
      if (tick_s && ms_q != 16'hFFFF) ms_inc_s = ms_q + 16'd1;
      else                            ms_inc_s = ms_q;
      state_d     = state_q;
      ms_d        = ms_q;
      post_s      = 1'b0;
      post_type_s = EVT_SHORT;
      case (state_q)
        ST_IDLE: begin
          if (!key_q[k]) begin
            state_d = ST_PRESSED;
            ms_d    = 16'd0;
          end else begin
            ms_d    = 16'd0;
          end
        end
        ST_PRESSED: begin
          if (key_q[k]) begin
            post_s  = 1'b1;
            state_d = ST_IDLE;
          end else if (ms_inc_s >= LONG_C) begin
            post_s      = 1'b1;
            post_type_s = EVT_LONG;
            state_d     = ST_LONG;
            ms_d        = 16'd0;
          end else begin
            ms_d = ms_inc_s;
          end
        end
        ST_LONG: begin
          if (key_q[k]) begin
            state_d = ST_IDLE;
            ms_d    = 16'd0;
          end else if (ms_inc_s >= REP_C) begin
            post_s      = 1'b1;
            post_type_s = EVT_REPEAT;
            ms_d        = 16'd0;
          end else begin
            ms_d = ms_inc_s;
          end
        end
        default: begin
          state_d = ST_IDLE;
          ms_d    = 16'd0;
        end
      endcase
    end

    // A slot granted this cycle counts as free, so a same-cycle re-post is kept
    assign grant_s         = grant_valid_s && (grant_idx_s == KW'(k));
    assign busy_s          = slot_valid_q && !grant_s;
    assign drop_s[k]       = post_s && busy_s;
    assign pend_valid_s[k] = slot_valid_q;
    assign pend_type_s[k]  = slot_type_q;

    // Key FSM state and pending event slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q      <= ST_IDLE;
        ms_q         <= 16'd0;
        slot_valid_q <= 1'b0;
        slot_type_q  <= EVT_SHORT;
      end else begin
        state_q <= state_d;
        ms_q    <= ms_d;
        if (post_s && !busy_s) begin
          slot_valid_q <= 1'b1;
          slot_type_q  <= post_type_s;
        end else if (grant_s) begin
          slot_valid_q <= 1'b0;
        end
      end
    end
  end

  // Round-robin grant: first pending key at or after the pointer
  always_comb begin
    logic [KW:0] cand;
    cand          = '0;
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cand = {1'b0, rr_ptr_q} + (KW+1)'(i);
      if (cand >= NK_C) cand = cand - NK_C;
      else              cand = cand;
      if (!fifo_full_s && !grant_valid_s && pend_valid_s[cand[KW-1:0]]) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = cand[KW-1:0];
      end
    end
    grant_type_s = pend_type_s[grant_idx_s];
    if (!grant_valid_s)             rr_ptr_d = rr_ptr_q;
    else if (grant_idx_s == LAST_KEY) rr_ptr_d = '0;
    else                            rr_ptr_d = grant_idx_s + KW'(1);
  end

  // FIFO occupancy and sticky drop flag
  always_comb begin
    fifo_full_s = (count_q == FULL_C);
    push_s      = grant_valid_s;
    pop_s       = evt_valid && evt_ready;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (|drop_s)           overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
    else                   overflow_d = overflow_q;
  end

  // Arbiter pointer, FIFO storage and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push_s) begin
        fifo_q[wr_ptr_q] <= {grant_idx_s, grant_type_s};
        wr_ptr_q         <= wr_ptr_q + AW'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  assign evt_valid           = (count_q != '0);
  assign {evt_key, evt_type} = fifo_q[rd_ptr_q];
  assign overflow            = overflow_q;

endmodule

// File: doc/key_event_ctrl.md
# key_event_ctrl

Multi-key event controller that sits behind a bank of key debouncers. It watches NUM_KEYS debounced key levels (idle high, pressed low) and classifies each key's activity as short press, long press or auto-repeat. It arbitrates events from all keys round-robin into a small FIFO and presents them to the application on a valid/ready interface.

## Interface
- NUM_KEYS, 4: number of keys; legal range 2..16.
- FREQ, 50: clk frequency in MHz; one ms tick every FREQ*1000 cycles.
- LONG_MS, 1000: hold time in ms that converts a press to a long press; must be ≥1.
- REPEAT_MS, 200: auto-repeat period in ms while held after a long press; must be ≥1.
- FIFO_DEPTH, 4: event FIFO entries; power of two, ≥2.

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- key_level  in  NUM_KEYS  debounced levels, 1 = released, 0 = pressed; synchronous to clk
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts the head event when evt_valid && evt_ready
- evt_key  out  clog2(NUM_KEYS)  key index of the head event
- evt_type  out  2  00 SHORT, 01 LONG, 10 REPEAT, 11 unused
- overflow  out  1  sticky; an event was dropped
- clr_overflow  in  1  clears overflow; if a drop occurs in the same cycle, overflow stays set

## Operation
- Reset values: evt_valid 0, evt_key 0, evt_type 00, overflow 0, all key FSMs IDLE, key_q all ones, pending slots empty, FIFO empty, round-robin pointer 0, tick counter 0.
- Tick: free-running counter 0..FREQ*1000-1; tick pulses one cycle at terminal count. Hold durations are therefore quantised to ±1 ms.
- key_q registers key_level. The FSM acts on key_q and a per-key saturating 16-bit ms counter.
- Per-key FSM:
  - IDLE: key_q=0 -> PRESSED, ms_cnt=0.
  - PRESSED: key_q=1 -> post SHORT, IDLE. On tick, ms_cnt+1. When ms_cnt reaches LONG_MS -> post LONG, LONG_HELD, ms_cnt=0.
  - LONG_HELD: on tick, ms_cnt+1. When ms_cnt reaches REPEAT_MS -> post REPEAT, ms_cnt=0. key_q=1 -> IDLE, no event.
- Pending slot: one slot per key holding {valid, type}. Posting into an occupied slot drops the new event and sets overflow; the old event is kept.
- Arbiter: each cycle the FIFO is not full, grant the first pending key at or after the round-robin pointer. Write {key, type} to the FIFO, clear the slot, and set pointer = grant+1 (mod NUM_KEYS). At most one grant per cycle.
- A slot cleared by a grant may be re-posted in the same cycle; the new event is kept and no overflow occurs.
- FIFO: push only if not full at cycle start. Push and pop may occur together; count is then unchanged. evt_valid = (count≠0). evt_key and evt_type show the head entry and hold stable while evt_valid && !evt_ready.
- A key already held low when rst_n deasserts is seen as a new press, because key_q resets to 1.

## Timing
- key_level change captured at edge E. FSM transition and pending post at E+1. FIFO write at E+2. evt_valid is high after E+2 when the FIFO was empty and there was no contention.
- Pop takes effect at the accepting edge. The next entry is visible in the following cycle with no bubble.
- With N keys pending simultaneously and the FIFO not full, N events are written on N consecutive cycles in round-robin order.
- rst_n assertion clears everything immediately, including FIFO contents and in-progress holds. No event is emitted for an interrupted press.

## Test plan
- Sim params FREQ=1, LONG_MS=5, REPEAT_MS=2, NUM_KEYS=4, evt_ready=1. Press key 2 for 2000 cycles -> exactly one event {key 2, SHORT}, evt_valid first high 3 edges after release.
- Hold key 1 for 12000 cycles -> LONG at ~5 ms, then REPEAT every 2 ms (3 REPEATs) -> 4 events total, nothing on release.
- Keys 0, 1, 3 released in the same cycle after short presses -> SHORT events in order 0, 1, 3 on consecutive cycles; a second burst starts from the pointer value left by the first.
- evt_ready=0, six short presses on distinct key/time pairs -> FIFO fills with 4 entries, evt_valid stays high with the head stable. Pending slots absorb the rest; a further post to an occupied slot sets overflow. A one-cycle clr_overflow pulse clears it.
- Simultaneous push and pop with the FIFO at 3 entries -> count stays 3 and order is preserved.
- Assert rst_n mid long-hold and with the FIFO non-empty -> evt_valid=0 and overflow=0 immediately. After release with the key still low, a new press is detected: LONG after 5 ms.
